// File: rtl/ctrl_seq_if.sv
// Bundle between the RISC Mini fetch/datapath side and the control sequencer.
// The master side presents instructions, condition codes and the DMEM
// acknowledge. The slave (sequencer) side returns the handshake, the mux
// selects, the DMEM strobes and the status pulses.
interface ctrl_seq_if #(
    parameter int XLEN = 32
);
    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst;
    logic [3:0]      ccr;
    logic [XLEN-1:0] pc_plus4;
    logic            dmem_ack;
    logic [1:0]      pc_sel;
    logic [XLEN-1:0] ras_top;
    logic            a_sel;
    logic            b_sel;
    logic            dmem_re;
    logic            dmem_we;
    logic            wb_sel;
    logic            reg_we;
    logic            illegal;
    logic            ras_err;

    modport master (
        output inst_valid, inst, ccr, pc_plus4, dmem_ack,
        input  inst_ready, pc_sel, ras_top, a_sel, b_sel,
               dmem_re, dmem_we, wb_sel, reg_we, illegal, ras_err
    );

    modport slave (
        input  inst_valid, inst, ccr, pc_plus4, dmem_ack,
        output inst_ready, pc_sel, ras_top, a_sel, b_sel,
               dmem_re, dmem_we, wb_sel, reg_we, illegal, ras_err
    );
endinterface

// File: rtl/ctrl_seq.sv
// Multi-cycle control sequencer for the RISC Mini core.
// EXEC decodes and completes every non-memory instruction in one cycle.
// M_TYPE instructions are latched, and the sequencer then waits in MEM for the
// DMEM acknowledge. CALL/RET use a small circular return-address stack.
module ctrl_seq #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    ctrl_seq_if.slave bus
);
    localparam int              RAS_AW   = $clog2(RAS_DEPTH);
    localparam logic [RAS_AW:0] RAS_FULL = (RAS_AW + 1)'(RAS_DEPTH);

    localparam logic [3:0] R_TYPE   = 4'h0;
    localparam logic [3:0] I_TYPE   = 4'h1;
    localparam logic [3:0] J_TYPE   = 4'h2;
    localparam logic [3:0] M_TYPE   = 4'h3;
    localparam logic [3:0] J_JUMP   = 4'h0;
    localparam logic [3:0] J_BRANCH = 4'h1;
    localparam logic [3:0] J_CALL   = 4'h2;
    localparam logic [3:0] J_RET    = 4'h3;
    localparam logic [3:0] M_LOAD   = 4'h0;
    localparam logic [3:0] M_STORE  = 4'h1;

    typedef enum logic {
        EXEC = 1'b0,
        MEM  = 1'b1
    } state_t;

    state_t            state_reg;
    logic              mem_store_reg;
    logic [RAS_AW-1:0] ptr_reg;
    logic [RAS_AW:0]   count_reg;
    logic [XLEN-1:0]   ras_mem [RAS_DEPTH];

    logic [3:0]        op_type;
    logic [3:0]        sub_op;
    logic              branch_taken;
    logic [RAS_AW-1:0] ptr_prev;
    logic              ras_empty;
    logic [20:0]       unused_inst_bits;

    logic              dec_ready;
    logic [1:0]        dec_pc_sel;
    logic              dec_a_sel;
    logic              dec_b_sel;
    logic              dec_dmem_re;
    logic              dec_dmem_we;
    logic              dec_wb_sel;
    logic              dec_reg_we;
    logic              dec_illegal;
    logic              dec_ras_err;
    logic              push;
    logic              pop;
    logic              go_mem;
    logic              mem_done;

    assign op_type          = bus.inst[3:0];
    assign sub_op           = bus.inst[7:4];
    assign branch_taken     = bus.ccr[bus.inst[9:8]] ^ bus.inst[10];
    assign ptr_prev         = ptr_reg - 1'b1;
    assign ras_empty        = (count_reg == '0);
    assign unused_inst_bits = bus.inst[31:11];

    // Decode the current instruction, or the latched memory op while in MEM.
    // Holding reset low forces every output to zero.
    always_comb begin
        dec_ready   = 1'b0;
        dec_pc_sel  = 2'd0;
        dec_a_sel   = 1'b0;
        dec_b_sel   = 1'b0;
        dec_dmem_re = 1'b0;
        dec_dmem_we = 1'b0;
        dec_wb_sel  = 1'b0;
        dec_reg_we  = 1'b0;
        dec_illegal = 1'b0;
        dec_ras_err = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        go_mem      = 1'b0;
        mem_done    = 1'b0;
        if (rst) begin
            if (state_reg == MEM) begin
                dec_b_sel = 1'b1;
                if (mem_store_reg) begin
                    dec_dmem_we = 1'b1;
                end else begin
                    dec_dmem_re = 1'b1;
                end
                if (bus.dmem_ack) begin
                    mem_done = 1'b1;
                    if (!mem_store_reg) begin
                        dec_wb_sel = 1'b1;
                        dec_reg_we = 1'b1;
                    end
                end
            end else begin
                dec_ready = 1'b1;
                if (bus.inst_valid) begin
                    case (op_type)
                        R_TYPE: dec_reg_we = 1'b1;
                        I_TYPE: begin
                            dec_b_sel  = 1'b1;
                            dec_reg_we = 1'b1;
                        end
                        J_TYPE: begin
                            case (sub_op)
                                J_JUMP: begin
                                    dec_pc_sel = 2'd1;
                                    dec_a_sel  = 1'b1;
                                    dec_b_sel  = 1'b1;
                                end
                                J_BRANCH: begin
                                    dec_pc_sel = branch_taken ? 2'd1 : 2'd0;
                                    dec_a_sel  = 1'b1;
                                    dec_b_sel  = 1'b1;
                                end
                                J_CALL: begin
                                    dec_pc_sel = 2'd1;
                                    dec_a_sel  = 1'b1;
                                    dec_b_sel  = 1'b1;
                                    push       = 1'b1;
                                end
                                J_RET: begin
                                    if (ras_empty) begin
                                        dec_ras_err = 1'b1;
                                    end else begin
                                        dec_pc_sel = 2'd2;
                                        pop        = 1'b1;
                                    end
                                end
                                default: dec_illegal = 1'b1;
                            endcase
                        end
                        M_TYPE: begin
                            if (sub_op == M_LOAD || sub_op == M_STORE) begin
                                go_mem = 1'b1;
                            end else begin
                                dec_illegal = 1'b1;
                            end
                        end
                        default: dec_illegal = 1'b1;
                    endcase
                end
            end
        end
    end

    // Control FSM plus RAS pointer/occupancy. Only the store/load bit of the
    // memory op needs to be kept, because MEM is entered for legal M_TYPE only.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= EXEC;
            mem_store_reg <= 1'b0;
            ptr_reg       <= '0;
            count_reg     <= '0;
        end else begin
            case (state_reg)
                EXEC: begin
                    if (go_mem) begin
                        state_reg     <= MEM;
                        mem_store_reg <= (sub_op == M_STORE);
                    end
                end
                MEM: begin
                    if (mem_done) begin
                        state_reg <= EXEC;
                    end
                end
                default: state_reg <= EXEC;
            endcase
            if (push) begin
                ptr_reg <= ptr_reg + 1'b1;
                if (count_reg != RAS_FULL) begin
                    count_reg <= count_reg + 1'b1;
                end
            end else if (pop) begin
                ptr_reg   <= ptr_prev;
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    // RAS storage. When the stack is full, a push lands on the oldest entry.
    always_ff @(posedge clk) begin
        if (push) begin
            ras_mem[ptr_reg] <= bus.pc_plus4;
        end
    end

    assign bus.inst_ready = dec_ready;
    assign bus.pc_sel     = dec_pc_sel;
    assign bus.ras_top    = (rst && !ras_empty) ? ras_mem[ptr_prev] : '0;
    assign bus.a_sel      = dec_a_sel;
    assign bus.b_sel      = dec_b_sel;
    assign bus.dmem_re    = dec_dmem_re;
    assign bus.dmem_we    = dec_dmem_we;
    assign bus.wb_sel     = dec_wb_sel;
    assign bus.reg_we     = dec_reg_we;
    assign bus.illegal    = dec_illegal;
    assign bus.ras_err    = dec_ras_err;
endmodule
